// File: rtl/shiftreg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_univ
//  Purpose  : Parametrised universal shift register. Supports shift left and
//             shift right, rotate, parallel load and clear. A shift counter
//             pulses word_done each time a full WIDTH-bit word has been
//             shifted in, so the block can act as a SIPO deserialiser.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      register width in bits (2..32)
//    RST_VAL    value of q while reset is asserted
//    LFSR_POLY  tap mask for the LFSR step (only with SHIFTREG_LFSR_EN)
//
//  Ports
//    clk        rising-edge clock
//    rst        asynchronous, active-low reset
//    en         cycle enable; 0 holds q/cnt and forces word_done low
//    mode[2:0]  000 hold, 001 shl, 010 shr, 011 load, 100 rol, 101 ror,
//               110 LFSR step (hold without SHIFTREG_LFSR_EN), 111 clear
//    sin_lsb    serial input into bit 0 on shift left
//    sin_msb    serial input into bit WIDTH-1 on shift right
//    par_in     parallel load data
//    q          register contents
//    sout_msb   q[WIDTH-1]
//    sout_lsb   q[0]
//    cnt        shifts since the last word boundary
//    word_done  one-cycle pulse after a full word has been shifted in
//
//  Build option
//    SHIFTREG_LFSR_EN  when defined, mode 110 performs a Fibonacci LFSR step
// ============================================================================
module shiftreg_univ #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RST_VAL   = '0,
    parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(4'b1001)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic                       sin_lsb,
    input  logic                       sin_msb,
    input  logic [WIDTH-1:0]           par_in,
    output logic [WIDTH-1:0]           q,
    output logic                       sout_msb,
    output logic                       sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       word_done
);

    localparam int unsigned c_CNT_W = $clog2(WIDTH + 1);

    // Counter value on which the next shift completes a word.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_SHL   = 3'b001;
    localparam logic [2:0] c_MODE_SHR   = 3'b010;
    localparam logic [2:0] c_MODE_LOAD  = 3'b011;
    localparam logic [2:0] c_MODE_ROL   = 3'b100;
    localparam logic [2:0] c_MODE_ROR   = 3'b101;
    localparam logic [2:0] c_MODE_LFSR  = 3'b110;
    localparam logic [2:0] c_MODE_CLEAR = 3'b111;

    // Elaboration-time range check on the width.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("shiftreg_univ: WIDTH must be in the range 2..32");
        end
    endgenerate

    logic [WIDTH-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_word_done;

    logic [WIDTH-1:0]   w_q_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_done_next;
    logic               w_shift;

    // Common counter handling for both shift directions: a shift that
    // completes the word wraps the counter and raises word_done.
    always_comb begin
        w_q_next    = r_q;
        w_cnt_next  = r_cnt;
        w_done_next = 1'b0;
        w_shift     = 1'b0;

        if (en) begin
            case (mode)
                c_MODE_HOLD: begin
                    w_q_next = r_q;
                end
                c_MODE_SHL: begin
                    w_q_next = {r_q[WIDTH-2:0], sin_lsb};
                    w_shift  = 1'b1;
                end
                c_MODE_SHR: begin
                    w_q_next = {sin_msb, r_q[WIDTH-1:1]};
                    w_shift  = 1'b1;
                end
                c_MODE_LOAD: begin
                    w_q_next   = par_in;
                    w_cnt_next = '0;
                end
                c_MODE_ROL: begin
                    w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                end
                c_MODE_ROR: begin
                    w_q_next = {r_q[0], r_q[WIDTH-1:1]};
                end
                c_MODE_LFSR: begin
`ifdef SHIFTREG_LFSR_EN
                    // Fibonacci step; an all-zero state is a fixed point.
                    w_q_next = {r_q[WIDTH-2:0], ^(r_q & LFSR_POLY)};
`else
                    w_q_next = r_q;
`endif
                end
                c_MODE_CLEAR: begin
                    // Clear goes to zero, deliberately not to RST_VAL.
                    w_q_next   = '0;
                    w_cnt_next = '0;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase

            if (w_shift) begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_next  = '0;
                    w_done_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q         <= RST_VAL;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_word_done <= w_done_next;
        end
    end

    assign q         = r_q;
    assign sout_msb  = r_q[WIDTH-1];
    assign sout_lsb  = r_q[0];
    assign cnt       = r_cnt;
    assign word_done = r_word_done;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shiftreg_univ
//  Purpose  : Directed self-checking bench for shiftreg_univ (WIDTH=4).
//             Expected values are hand-computed constants.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_shiftreg_univ;

    localparam int unsigned c_WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               en;
    logic [2:0]         mode;
    logic               sin_lsb;
    logic               sin_msb;
    logic [c_WIDTH-1:0] par_in;
    logic [c_WIDTH-1:0] q;
    logic               sout_msb;
    logic               sout_lsb;
    logic [2:0]         cnt;
    logic               word_done;

    int n_tests;
    int n_fail;

    shiftreg_univ #(
        .WIDTH     (c_WIDTH),
        .RST_VAL   (4'b0000),
        .LFSR_POLY (4'b1001)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_lsb   (sin_lsb),
        .sin_msb   (sin_msb),
        .par_in    (par_in),
        .q         (q),
        .sout_msb  (sout_msb),
        .sout_lsb  (sout_lsb),
        .cnt       (cnt),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] eq,
                                input logic [2:0] ec, input logic ed);
        logic [3:0] e;
        e = eq;
        check({tag, ".q"},        32'(q),         32'(e));
        check({tag, ".cnt"},      32'(cnt),       32'(ec));
        check({tag, ".done"},     32'(word_done), 32'(ed));
        check({tag, ".sout_msb"}, 32'(sout_msb),  32'(e[3]));
        check({tag, ".sout_lsb"}, 32'(sout_lsb),  32'(e[0]));
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic e, input logic [2:0] m, input logic sl,
                        input logic sr, input logic [3:0] p);
        en      = e;
        mode    = m;
        sin_lsb = sl;
        sin_msb = sr;
        par_in  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        en      = 1'b0;
        mode    = 3'b000;
        sin_lsb = 1'b0;
        sin_msb = 1'b0;
        par_in  = 4'b0000;

        #2;
        expect_state("reset", 4'b0000, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: serial-in left, word assembled after four shifts.
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t1.s1", 4'b0001, 3'd1, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0); expect_state("t1.s2", 4'b0010, 3'd2, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t1.s3", 4'b0101, 3'd3, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t1.s4", 4'b1011, 3'd0, 1'b1);
        step(1, 3'b000, 0, 0, 4'h0); expect_state("t1.hold", 4'b1011, 3'd0, 1'b0);

        // 2: load, rotate right, rotate left.
        step(1, 3'b011, 0, 0, 4'b1001); expect_state("t2.load", 4'b1001, 3'd0, 1'b0);
        step(1, 3'b101, 0, 0, 4'h0);    expect_state("t2.ror",  4'b1100, 3'd0, 1'b0);
        step(1, 3'b100, 0, 0, 4'h0);    expect_state("t2.rol",  4'b1001, 3'd0, 1'b0);

        // 3: clear, shift right twice, load resets cnt, four shift-lefts.
        step(1, 3'b111, 0, 0, 4'h0);    expect_state("t3.clr",  4'b0000, 3'd0, 1'b0);
        step(1, 3'b010, 0, 1, 4'h0);    expect_state("t3.sr1",  4'b1000, 3'd1, 1'b0);
        step(1, 3'b010, 0, 1, 4'h0);    expect_state("t3.sr2",  4'b1100, 3'd2, 1'b0);
        step(1, 3'b011, 0, 0, 4'b0101); expect_state("t3.load", 4'b0101, 3'd0, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0);    expect_state("t3.sl1",  4'b1010, 3'd1, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0);    expect_state("t3.sl2",  4'b0100, 3'd2, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0);    expect_state("t3.sl3",  4'b1000, 3'd3, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0);    expect_state("t3.sl4",  4'b0000, 3'd0, 1'b1);

        // Load at cnt=WIDTH-1 must clear cnt and suppress word_done.
        step(1, 3'b001, 1, 0, 4'h0);    expect_state("t3b.sl1", 4'b0001, 3'd1, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0);    expect_state("t3b.sl2", 4'b0011, 3'd2, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0);    expect_state("t3b.sl3", 4'b0111, 3'd3, 1'b0);
        step(1, 3'b011, 1, 0, 4'b0110); expect_state("t3b.ld",  4'b0110, 3'd0, 1'b0);
        step(1, 3'b111, 0, 0, 4'h0);    expect_state("t3b.clr", 4'b0000, 3'd0, 1'b0);

        // 4: enable gating.
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t4.sl1", 4'b0001, 3'd1, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t4.sl2", 4'b0011, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b001, 1, 1, 4'hF);
            expect_state($sformatf("t4.en0_%0d", i), 4'b0011, 3'd2, 1'b0);
        end
        step(1, 3'b001, 0, 0, 4'h0); expect_state("t4.sl3", 4'b0110, 3'd3, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0); expect_state("t4.sl4", 4'b1100, 3'd0, 1'b1);
        step(0, 3'b001, 1, 0, 4'h0); expect_state("t4.dis", 4'b1100, 3'd0, 1'b0);

        // 5: asynchronous reset mid-word.
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.sl1", 4'b1001, 3'd1, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.sl2", 4'b0011, 3'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        expect_state("t5.arst", 4'b0000, 3'd0, 1'b0);
        #2;
        rst = 1'b1;
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.r1", 4'b0001, 3'd1, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.r2", 4'b0011, 3'd2, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.r3", 4'b0111, 3'd3, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t5.r4", 4'b1111, 3'd0, 1'b1);

        // 6: LFSR mode (hold when the feature is not built).
        step(1, 3'b011, 0, 0, 4'b0001); expect_state("t6.load", 4'b0001, 3'd0, 1'b0);
`ifdef SHIFTREG_LFSR_EN
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l1", 4'b0011, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l2", 4'b0111, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l3", 4'b1111, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l4", 4'b1110, 3'd0, 1'b0);
`else
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l1", 4'b0001, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l2", 4'b0001, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l3", 4'b0001, 3'd0, 1'b0);
        step(1, 3'b110, 0, 0, 4'h0); expect_state("t6.l4", 4'b0001, 3'd0, 1'b0);
`endif

        // 7: mixed directions keep counting; rotate leaves cnt alone.
        step(1, 3'b111, 0, 0, 4'h0); expect_state("t7.clr", 4'b0000, 3'd0, 1'b0);
        step(1, 3'b001, 1, 0, 4'h0); expect_state("t7.sl1", 4'b0001, 3'd1, 1'b0);
        step(1, 3'b010, 0, 1, 4'h0); expect_state("t7.sr1", 4'b1000, 3'd2, 1'b0);
        step(1, 3'b100, 0, 0, 4'h0); expect_state("t7.rol", 4'b0001, 3'd2, 1'b0);
        step(1, 3'b001, 0, 0, 4'h0); expect_state("t7.sl2", 4'b0010, 3'd3, 1'b0);
        step(1, 3'b010, 0, 1, 4'h0); expect_state("t7.sr2", 4'b1001, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shiftreg_univ.md
Name: shiftreg_univ

Overview:
Parametrised universal shift register. Generalises the fixed 4-bit serial-in/serial-out shifter to WIDTH bits and adds the following:
- Bidirectional shift, rotate, parallel load and clear.
- A shift counter that flags each time a full word has been shifted in, so the block works as a SIPO deserialiser.

Used as a serial-link front end and general-purpose data-path shifter in the lab designs.

Parameters:
WIDTH, 4, register width in bits; legal range 2..32.
RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
LFSR_POLY, 4'b1001 (WIDTH bits), tap mask for LFSR mode; used only with SHIFTREG_LFSR_EN.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
en  in  1  cycle enable; 0 = hold all state.
mode  in  3  operation select; see Behaviour.
sin_lsb  in  1  serial input into bit 0 on shift-left.
sin_msb  in  1  serial input into bit WIDTH-1 on shift-right.
par_in  in  WIDTH  parallel load data.
q  out  WIDTH  register contents.
sout_msb  out  1  q[WIDTH-1], combinational from register.
sout_lsb  out  1  q[0], combinational from register.
cnt  out  clog2(WIDTH+1)  number of shifts since last word boundary.
word_done  out  1  one-cycle pulse: full word shifted in.

Behaviour:
Reset:
- rst low forces q=RST_VAL, cnt=0, word_done=0 immediately, with no clock edge needed.
- Reset takes priority over everything, including a shift in progress.
- Release is sampled synchronously; the first operation happens on the first rising edge with rst high.

All other state changes occur on the rising edge of clk, only when en=1.

Modes (en=1):
- 000 hold: q and cnt unchanged.
- 001 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
- 010 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
- 011 load: q <= par_in; cnt <= 0.
- 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 101 rotate right: q <= {q[0], q[WIDTH-1:1]}.
- 110 LFSR when SHIFTREG_LFSR_EN is defined; hold otherwise.
- 111 clear: q <= 0 (not RST_VAL); cnt <= 0.

Counter and word_done:
- Only modes 001 and 010 increment cnt.
- Rotate, LFSR and hold leave cnt unchanged.
- On the shift edge where cnt would reach WIDTH: cnt wraps to 0 and word_done is set to 1 for exactly the next cycle. At that point q holds the complete word.
- word_done is registered and is 0 on every other edge.
- word_done is 0 after any edge with en=0, even if it was 1 before.
- Mixing left and right shifts still counts every shift; direction changes do not reset cnt.
- Load and clear reset cnt to 0 and suppress word_done, even if cnt was WIDTH-1.

Other rules:
- en=0: q and cnt are held; word_done is forced low on that edge.
- Latency: one clock from input sample to q update. sout_* follow q with no extra delay.
- Out-of-range mode values are impossible (3 bits are fully decoded).

Optional Feature:
Macro SHIFTREG_LFSR_EN.
- Defined: mode 110 is a Fibonacci LFSR step, q <= {q[WIDTH-2:0], ^(q & LFSR_POLY)}. cnt is unchanged and word_done is 0.
  - An all-zero q stays all-zero; no lock-up escape is provided, so software seeds via load.
- Undefined: mode 110 behaves as hold, and no LFSR logic or LFSR_POLY use is synthesised.

Test Plan:
1. WIDTH=4. Reset, then mode=001 with sin_lsb=1,0,1,1 on four edges -> q=4'b1011 and cnt=0 after the 4th edge, word_done=1 for exactly that following cycle and 0 otherwise. cnt reads 1,2,3 after the first three edges.
2. Load par_in=4'b1001, then one rotate-right -> q=4'b1100 with cnt=0. Then one rotate-left -> q=4'b1001, cnt still 0, word_done never asserted.
3. From q=0: shift right twice with sin_msb=1 -> q=4'b1100, cnt=2. Then load 4'b0101 -> q=4'b0101, cnt=0, no word_done. Then 4 shift-lefts -> word_done on the 4th.
4. Shift left twice, drop en for 3 cycles with mode=001, then shift twice more -> q unchanged while en=0, word_done after the 4th enabled shift only.
5. Mid-sequence (cnt=2), drive rst low 3 ns after a rising edge -> q=RST_VAL, cnt=0, word_done=0 before the next edge. After release, 4 shifts are needed for word_done.
6. With SHIFTREG_LFSR_EN and LFSR_POLY=4'b1001: load 4'b0001, then mode=110 for four edges -> q=0011, 0111, 1111, 1110, with cnt=0 throughout. Without the macro the same stimulus leaves q=0001.
